// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter_if
// Purpose  : Two-master request/ack bus plus the shared data-memory pins.
// Revision : 1.0
// ============================================================================
interface dm_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_write;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_write;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;

    logic              DM_enable;
    logic              DM_read;
    logic              DM_write;
    logic [ADDR_W-1:0] DM_address;
    logic [DATA_W-1:0] DM_in;
    logic [DATA_W-1:0] DM_out;

    logic              busy;
    logic [1:0]        grant;

    // Arbiter side
    modport slave (
        input  m0_req, m0_write, m0_addr, m0_wdata,
        input  m1_req, m1_write, m1_addr, m1_wdata,
        input  DM_out,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output DM_enable, DM_read, DM_write, DM_address, DM_in,
        output busy, grant
    );

    // Requesters and memory side
    modport master (
        output m0_req, m0_write, m0_addr, m0_wdata,
        output m1_req, m1_write, m1_addr, m1_wdata,
        output DM_out,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  DM_enable, DM_read, DM_write, DM_address, DM_in,
        input  busy, grant
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Round-robin sharing of one data-memory port between two masters
//            with a fixed, parameterised access latency and one-cycle ack.
// Revision : 1.0
// ============================================================================
module dm_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  wire logic   clock,
    input  wire logic   reset,
    dm_arbiter_if.slave bus
);
    localparam int                 c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MEM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_last_grant;
    logic [1:0]          r_grant;
    logic                r_busy;
    logic                r_en;
    logic                r_rd;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_any_req;
    logic                w_pick_m1;
    logic                w_write;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    assign w_any_req = bus.m0_req | bus.m1_req;
    // On a tie the master that was not served last wins.
    assign w_pick_m1 = bus.m1_req & (~bus.m0_req | ~r_last_grant);
    assign w_write   = w_pick_m1 ? bus.m1_write : bus.m0_write;
    assign w_addr    = w_pick_m1 ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata   = w_pick_m1 ? bus.m1_wdata : bus.m0_wdata;

    // The DM strobe registers double as the latched command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_en         <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_ack        <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_LAT;
                        r_en    <= 1'b1;
                        r_rd    <= ~w_write;
                        r_wr    <= w_write;
                        r_addr  <= w_addr;
                        r_din   <= w_write ? w_wdata : '0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        if (!r_wr) begin
                            if (r_grant[0]) r_rdata0 <= bus.DM_out;
                            else            r_rdata1 <= bus.DM_out;
                        end
                        r_en    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= '0;
                        r_din   <= '0;
                        r_ack   <= r_grant;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant[1];
                    r_grant      <= 2'b00;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.DM_enable  = r_en;
    assign bus.DM_read    = r_rd;
    assign bus.DM_write   = r_wr;
    assign bus.DM_address = r_addr;
    assign bus.DM_in      = r_din;
    assign bus.m0_ack     = r_ack[0];
    assign bus.m1_ack     = r_ack[1];
    assign bus.m0_rdata   = r_rdata0;
    assign bus.m1_rdata   = r_rdata1;
    assign bus.busy       = r_busy;
    assign bus.grant      = r_grant;
endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Directed and random checks of dm_arbiter at latencies 1 and 3
//            against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_dm_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );
    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // Stimulus arrays: [dut][master]
    logic          d_req   [2][2];
    logic          d_wr    [2][2];
    logic [AW-1:0] d_addr  [2][2];
    logic [DW-1:0] d_wd    [2][2];
    logic [DW-1:0] d_dmout [2];

    assign bus0.m0_req   = d_req[0][0];
    assign bus0.m0_write = d_wr[0][0];
    assign bus0.m0_addr  = d_addr[0][0];
    assign bus0.m0_wdata = d_wd[0][0];
    assign bus0.m1_req   = d_req[0][1];
    assign bus0.m1_write = d_wr[0][1];
    assign bus0.m1_addr  = d_addr[0][1];
    assign bus0.m1_wdata = d_wd[0][1];
    assign bus0.DM_out   = d_dmout[0];
    assign bus1.m0_req   = d_req[1][0];
    assign bus1.m0_write = d_wr[1][0];
    assign bus1.m0_addr  = d_addr[1][0];
    assign bus1.m0_wdata = d_wd[1][0];
    assign bus1.m1_req   = d_req[1][1];
    assign bus1.m1_write = d_wr[1][1];
    assign bus1.m1_addr  = d_addr[1][1];
    assign bus1.m1_wdata = d_wd[1][1];
    assign bus1.DM_out   = d_dmout[1];

    typedef struct packed {
        logic          en;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          busy;
        logic [1:0]    grant;
        logic [1:0]    ack;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } obs_t;

    obs_t obs0, obs1;
    always_comb begin
        obs0 = {bus0.DM_enable, bus0.DM_read, bus0.DM_write, bus0.DM_address, bus0.DM_in,
                bus0.busy, bus0.grant, bus0.m1_ack, bus0.m0_ack, bus0.m0_rdata, bus0.m1_rdata};
        obs1 = {bus1.DM_enable, bus1.DM_read, bus1.DM_write, bus1.DM_address, bus1.DM_in,
                bus1.busy, bus1.grant, bus1.m1_ack, bus1.m0_ack, bus1.m0_rdata, bus1.m1_rdata};
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one in-flight transaction per DUT, tracked by its age
    // in clock edges since the arbitration edge.
    bit            m_active [2];
    int            m_age    [2];
    int            m_owner  [2];
    int            m_last   [2];
    bit            m_cw     [2];
    logic [AW-1:0] m_ca     [2];
    logic [DW-1:0] m_cd     [2];
    logic [DW-1:0] m_rdata  [2][2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic obs_t get_obs(input int k);
        return (k == 0) ? obs0 : obs1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k]   = 1'b0;
            m_age[k]      = 0;
            m_owner[k]    = 0;
            m_last[k]     = 1;
            m_rdata[k][0] = '0;
            m_rdata[k][1] = '0;
        end
    endtask

    task automatic model_edge(input int k);
        int w;
        if (!m_active[k]) begin
            if (d_req[k][0] || d_req[k][1]) begin
                if (d_req[k][0] && d_req[k][1]) w = 1 - m_last[k];
                else                            w = d_req[k][0] ? 0 : 1;
                m_active[k] = 1'b1;
                m_age[k]    = 0;
                m_owner[k]  = w;
                m_cw[k]     = d_wr[k][w];
                m_ca[k]     = d_addr[k][w];
                m_cd[k]     = d_wd[k][w];
            end
        end else begin
            m_age[k]++;
            if (m_age[k] == lat_of(k) && !m_cw[k]) m_rdata[k][m_owner[k]] = d_dmout[k];
            if (m_age[k] == lat_of(k) + 1) begin
                m_active[k] = 1'b0;
                m_last[k]   = m_owner[k];
            end
        end
    endtask

    function automatic obs_t exp_obs(input int k);
        obs_t e;
        e     = '0;
        e.rd0 = m_rdata[k][0];
        e.rd1 = m_rdata[k][1];
        if (m_active[k]) begin
            e.busy  = 1'b1;
            e.grant = (m_owner[k] == 0) ? 2'b01 : 2'b10;
            if (m_age[k] < lat_of(k)) begin
                e.en   = 1'b1;
                e.rd   = !m_cw[k];
                e.wr   = m_cw[k];
                e.addr = m_ca[k];
                e.din  = m_cw[k] ? m_cd[k] : '0;
            end else begin
                e.ack = e.grant;
            end
        end
        return e;
    endfunction

    function automatic bit exp_ack(input int k, input int m);
        return m_active[k] && (m_age[k] == lat_of(k)) && (m_owner[k] == m);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int k);
        obs_t o, e;
        o = get_obs(k);
        e = exp_obs(k);
        chk($sformatf("d%0d.DM_enable", k),  64'(o.en),    64'(e.en));
        chk($sformatf("d%0d.DM_read", k),    64'(o.rd),    64'(e.rd));
        chk($sformatf("d%0d.DM_write", k),   64'(o.wr),    64'(e.wr));
        chk($sformatf("d%0d.DM_address", k), 64'(o.addr),  64'(e.addr));
        chk($sformatf("d%0d.DM_in", k),      64'(o.din),   64'(e.din));
        chk($sformatf("d%0d.busy", k),       64'(o.busy),  64'(e.busy));
        chk($sformatf("d%0d.grant", k),      64'(o.grant), 64'(e.grant));
        chk($sformatf("d%0d.ack", k),        64'(o.ack),   64'(e.ack));
        chk($sformatf("d%0d.m0_rdata", k),   64'(o.rd0),   64'(e.rd0));
        chk($sformatf("d%0d.m1_rdata", k),   64'(o.rd1),   64'(e.rd1));
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clock);
        if (reset) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic new_cmd(input int k, input int m);
        d_wr[k][m]   = 1'($urandom_range(1, 0));
        d_addr[k][m] = AW'($urandom);
        d_wd[k][m]   = $urandom;
    endtask

    task automatic rand_masters();
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (d_req[k][m]) begin
                    if (exp_ack(k, m)) begin
                        if ($urandom_range(1, 0) == 0) d_req[k][m] = 1'b0;
                        else                          new_cmd(k, m);
                    end else if ($urandom_range(31, 0) == 0) begin
                        d_req[k][m] = 1'b0;
                    end else if ($urandom_range(15, 0) == 0) begin
                        new_cmd(k, m);
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    d_req[k][m] = 1'b1;
                    new_cmd(k, m);
                end
            end
            d_dmout[k] = $urandom;
        end
    endtask

    initial begin
        obs_t o;
        int   ack_who [$];
        int   ack_cyc [$];
        int   en_cnt;
        int   ack_cnt;

        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                d_req[k][m]  = 1'b0;
                d_wr[k][m]   = 1'b0;
                d_addr[k][m] = '0;
                d_wd[k][m]   = '0;
            end
            d_dmout[k] = '0;
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_all(0);
        check_all(1);
        o = get_obs(1);
        chk("rst.grant", 64'(o.grant), 64'd0);
        chk("rst.busy",  64'(o.busy),  64'd0);
        reset = 1'b1;

        // Latency 1: m0 read of 0x010
        d_req[0][0] = 1'b1; d_wr[0][0] = 1'b0; d_addr[0][0] = 12'h010;
        d_dmout[0]  = 32'hDEADBEEF;
        step();
        o = get_obs(0);
        chk("t1.DM_enable",  64'(o.en),   64'd1);
        chk("t1.DM_read",    64'(o.rd),   64'd1);
        chk("t1.DM_address", 64'(o.addr), 64'h010);
        step();
        o = get_obs(0);
        chk("t1.m0_ack",   64'(o.ack[0]), 64'd1);
        chk("t1.m1_ack",   64'(o.ack[1]), 64'd0);
        chk("t1.m0_rdata", 64'(o.rd0),    64'hDEADBEEF);
        d_req[0][0] = 1'b0;
        step();

        // Latency 1: m1 write of 0x12345678 to 0xFFF
        d_req[0][1] = 1'b1; d_wr[0][1] = 1'b1; d_addr[0][1] = 12'hFFF; d_wd[0][1] = 32'h12345678;
        step();
        o = get_obs(0);
        chk("t2.DM_write", 64'(o.wr),  64'd1);
        chk("t2.DM_read",  64'(o.rd),  64'd0);
        chk("t2.DM_in",    64'(o.din), 64'h12345678);
        step();
        o = get_obs(0);
        chk("t2.m1_ack",   64'(o.ack[1]), 64'd1);
        chk("t2.m1_rdata", 64'(o.rd1),    64'd0);
        chk("t2.m0_rdata", 64'(o.rd0),    64'hDEADBEEF);
        d_req[0][1] = 1'b0;
        step();

        // Latency 1: both masters request continuously
        d_req[0][0] = 1'b1; d_wr[0][0] = 1'b0; d_addr[0][0] = 12'h100;
        d_req[0][1] = 1'b1; d_wr[0][1] = 1'b1; d_addr[0][1] = 12'h200; d_wd[0][1] = 32'hCAFE0001;
        for (int i = 1; i <= 12; i++) begin
            step();
            o = get_obs(0);
            if (o.ack[0]) begin ack_who.push_back(0); ack_cyc.push_back(i); end
            if (o.ack[1]) begin ack_who.push_back(1); ack_cyc.push_back(i); end
        end
        chk("t3.n_acks", 64'(ack_who.size()), 64'd4);
        if (ack_cyc.size() > 0) chk("t3.first_ack_cycle", 64'(ack_cyc[0]), 64'd2);
        for (int i = 0; i < ack_who.size(); i++)
            chk($sformatf("t3.order%0d", i), 64'(ack_who[i]), 64'(i % 2));
        for (int i = 1; i < ack_cyc.size(); i++)
            chk($sformatf("t3.spacing%0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
        d_req[0][0] = 1'b0; d_req[0][1] = 1'b0;
        step();
        step();

        // Latency 3: m0 read while DM_out changes every cycle
        d_req[1][0] = 1'b1; d_wr[1][0] = 1'b0; d_addr[1][0] = 12'h055;
        d_dmout[1]  = 32'h0;
        en_cnt = 0;
        step();
        o = get_obs(1);
        en_cnt += int'(o.en);
        for (int i = 0; i < 3; i++) begin
            d_dmout[1] = 32'hA + 32'(i);
            step();
            o = get_obs(1);
            en_cnt += int'(o.en);
        end
        chk("t4.m0_ack_cycle4", 64'(o.ack[0]), 64'd1);
        chk("t4.m0_rdata",      64'(o.rd0),    64'hC);
        d_req[1][0] = 1'b0;
        step();
        o = get_obs(1);
        en_cnt += int'(o.en);
        chk("t4.enable_cycles", 64'(en_cnt), 64'd3);

        // Latency 3: reset asserted in the second access cycle
        d_req[1][0] = 1'b1; d_wr[1][0] = 1'b0; d_addr[1][0] = 12'h0A0;
        d_req[1][1] = 1'b1; d_wr[1][1] = 1'b0; d_addr[1][1] = 12'h0B0;
        step();
        o = get_obs(1);
        chk("t5.grant_m1", 64'(o.grant), 64'b10);
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        o = get_obs(1);
        chk("t5.async_DM_enable", 64'(o.en),    64'd0);
        chk("t5.async_grant",     64'(o.grant), 64'd0);
        chk("t5.async_ack",       64'(o.ack),   64'd0);
        check_all(0);
        check_all(1);
        @(posedge clock);
        #1;
        check_all(1);
        reset = 1'b1;
        step();
        o = get_obs(1);
        chk("t5.tie_after_reset", 64'(o.grant), 64'b01);

        // Latency 3: requests withdrawn mid-access
        d_req[1][0] = 1'b0; d_req[1][1] = 1'b0;
        en_cnt  = 0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            o = get_obs(1);
            en_cnt  += int'(o.en);
            ack_cnt += int'(o.ack[0]) + int'(o.ack[1]);
        end
        chk("t6.ack_count",    64'(ack_cnt), 64'd1);
        chk("t6.enable_count", 64'(en_cnt),  64'd2);

        // Random traffic on both instances
        repeat (3000) begin
            rand_masters();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the single data-memory port (DM_*) between two requesters: master 0 is the core's memaccess stage and master 1 is a secondary master (debug/DMA loader). The block arbitrates round-robin and latches the winning command. It sequences the DM strobes over a fixed, parameterised memory latency, captures read data and returns a one-cycle acknowledge to the winner. It sits between the core and data memory; the DM_* pins it drives replace the core's direct DM connections.

Parameters:
ADDR_W, 12, DM address width
DATA_W, 32, DM data width
MEM_LATENCY, 1, cycles DM_enable is held per access; DM_out sampled on the last of them; legal range 1..15

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 request, held until m0_ack
m0_write  in  1  1=write, 0=read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_rdata  out  DATA_W  master 0 read data
m0_ack  out  1  master 0 completion pulse
m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1
DM_enable  out  1  memory enable
DM_read  out  1  memory read strobe
DM_write  out  1  memory write strobe
DM_address  out  ADDR_W  memory address
DM_in  out  DATA_W  memory write data
DM_out  in  DATA_W  memory read data
busy  out  1  high while state != IDLE
grant  out  2  one-hot owner of the current transaction; 00 in IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; latched cmd=0; last_grant=1, so master 0 wins the first tie; counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay; DM_* = 0.
- IDLE, exactly one req: grant that master.
- IDLE, both req: grant the master != last_grant.
- IDLE, on grant: latch addr/write/wdata of the winner, set counter=MEM_LATENCY, go to ACCESS.
- ACCESS:
  - DM_enable=1; DM_read=~cmd_write; DM_write=cmd_write; DM_address/DM_in driven from the latch (DM_in=0 on reads).
  - counter decrements each cycle.
  - On the cycle counter==1: if read, register DM_out into the granted master's rdata; go to RESP.
- RESP:
  - DM_* = 0; granted mN_ack=1 for exactly this cycle.
  - last_grant updated to the served master; go to IDLE.
- Timing:
  - Req first seen high in IDLE at cycle T: ACCESS occupies T+1..T+MEM_LATENCY, ack at T+MEM_LATENCY+1.
  - Minimum issue interval is MEM_LATENCY+2 cycles.
- grant is registered and valid from the first ACCESS cycle through RESP.
- Requester rules:
  - Command must stay stable while req is high and before ack. Changes after the IDLE latch cycle are ignored.
  - req still high in the cycle after ack is treated as a new request.
- mN_rdata holds its value until the next read completion for that master. Writes never alter rdata.
- Request withdrawn mid-transaction: the access still completes and ack still pulses.
- A req arriving during ACCESS/RESP waits; it is arbitrated in the next IDLE cycle.
- Reset asserted mid-transaction: DM_enable/DM_read/DM_write drop immediately (async); no ack; pending command discarded.
- The non-granted master never sees ack and its rdata is unchanged.

Test Plan:
1. MEM_LATENCY=1; m0 read addr 0x010 at cycle 0, DM_out=0xDEADBEEF -> DM_enable/DM_read high cycle 1 with DM_address=0x010; m0_ack cycle 2; m0_rdata=0xDEADBEEF; m1_ack stays 0.
2. m1 write addr 0xFFF, data 0x12345678 -> one ACCESS cycle with DM_write=1, DM_in=0x12345678; m1_ack pulse; m1_rdata unchanged (0).
3. Both req held continuously from reset release -> service order m0, m1, m0, m1; acks spaced MEM_LATENCY+2 cycles; grant alternates 01/10.
4. MEM_LATENCY=3; m0 read, DM_out changes each cycle (0xA, 0xB, 0xC) -> DM_enable high exactly 3 cycles; m0_rdata=0xC; ack on cycle 4.
5. Reset pulsed low during cycle 2 of a 3-cycle access -> DM_enable=0 immediately, no ack, grant=00. After release, m0 wins a tie.
6. m0 drops req during ACCESS -> m0_ack still pulses once; FSM returns to IDLE; no further DM activity.
